// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: op codes, FSM states, widths and the
// single-cycle ALU function.
package exec_pkg;
  localparam int DATA_W = 8;
  localparam int ITER_N = 8;
  localparam int RES_W  = 2 * DATA_W;
  localparam logic [2:0] RD_LAST = 3'd7;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL1 = 3'b101,
    OP_MUL  = 3'b110,
    OP_DIV  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_WB
  } state_e;

  // Returns {carry/borrow/shifted-out bit, 8-bit result}.
  function automatic logic [DATA_W:0] alu_f(input op_e op, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL1: r = {a, 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/exec_if.sv
// Request/response bundle between the issue side and the execute stage.
interface exec_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic [2:0] rd_sel;
  logic       busy;
  logic       done;
  logic       r_w;
  logic [2:0] rd_addr;
  logic [15:0] rd_data;
  logic       input_length;
  logic       flag_z;
  logic       flag_c;
  logic       flag_err;

  modport master (
    output start, op, rs1_data, rs2_data, rd_sel,
    input  busy, done, r_w, rd_addr, rd_data, input_length, flag_z, flag_c, flag_err
  );
  modport slave (
    input  start, op, rs1_data, rs2_data, rd_sel,
    output busy, done, r_w, rd_addr, rd_data, input_length, flag_z, flag_c, flag_err
  );
endinterface

// File: rtl/exec_unit_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider sharing a
// hi/lo register pair; o_res_nxt is the result as it will be after the current step.
module muldiv_iter
  import exec_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [RES_W-1:0]  o_res_nxt,
  output logic              o_last
);
  logic [DATA_W-1:0] r_hi, r_lo;
  logic [3:0]        r_cnt;

  logic [DATA_W:0]   w_sum;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_n, w_q_n, w_hi_n, w_lo_n;

  // MUL: hi accumulates, lo holds the multiplier and fills with product bits.
  assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? i_b : '0)};

  // DIV: hi is the partial remainder, lo shifts the dividend out and quotient in.
  // The restored remainder is always below the divisor, so 8-bit wraparound is exact.
  assign w_ge    = {r_hi, r_lo[DATA_W-1]} >= {1'b0, i_b};
  assign w_rem_n = w_ge ? ({r_hi[DATA_W-2:0], r_lo[DATA_W-1]} - i_b)
                        : {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
  assign w_q_n   = {r_lo[DATA_W-2:0], w_ge};

  assign w_hi_n = i_is_div ? w_rem_n : w_sum[DATA_W:1];
  assign w_lo_n = i_is_div ? w_q_n   : {w_sum[0], r_lo[DATA_W-1:1]};

  assign o_res_nxt = i_is_div ? {w_lo_n, w_hi_n} : {w_hi_n, w_lo_n};
  assign o_last    = (r_cnt == 4'(ITER_N - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_cnt <= '0;
    end else if (i_step) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: accepts one op at a time, runs the ALU or the iterative MUL/DIV,
// and issues a single registered write-back cycle to the register file.
module exec_unit
  import exec_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  exec_if.slave bus
);
  state_e            r_state;
  op_e               r_op;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_rd;
  logic              r_busy, r_done, r_rw, r_len, r_z, r_c, r_err;
  logic [2:0]        r_rd_addr;
  logic [RES_W-1:0]  r_rd_data;

  op_e              w_op;
  logic             w_muldiv, w_div0, w_load, w_step, w_last;
  logic [DATA_W:0]  w_alu;
  logic [RES_W-1:0] w_res_nxt;

  assign w_op     = op_e'(bus.op);
  assign w_muldiv = (bus.op[2:1] == 2'b11);
  assign w_div0   = (w_op == OP_DIV) && (bus.rs2_data == '0);
  assign w_load   = (r_state == S_IDLE) && bus.start && w_muldiv && !w_div0;
  assign w_step   = (r_state == S_ITER);
  assign w_alu    = alu_f(w_op, bus.rs1_data, bus.rs2_data);

  muldiv_iter u_muldiv (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_is_div  (r_op == OP_DIV),
    .i_a       (bus.rs1_data),
    .i_b       (r_b),
    .o_res_nxt (w_res_nxt),
    .o_last    (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_b       <= '0;
      r_rd      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rw      <= 1'b1;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_len     <= 1'b0;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_rw   <= 1'b1;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_op   <= w_op;
          r_b    <= bus.rs2_data;
          r_rd   <= bus.rd_sel;
          r_busy <= 1'b1;
          if (w_muldiv && !w_div0) begin
            r_state <= S_ITER;
          end else begin
            r_state   <= S_WB;
            r_done    <= 1'b1;
            r_rd_addr <= bus.rd_sel;
            if (w_div0) begin
              // Divide by zero skips iteration; a pair write to R7 would wrap to R0.
              r_rd_data <= {8'hFF, bus.rs1_data};
              r_len     <= 1'b1;
              r_z       <= 1'b0;
              r_c       <= 1'b0;
              r_err     <= 1'b1;
              r_rw      <= (bus.rd_sel == RD_LAST);
            end else begin
              r_rd_data <= {8'h00, w_alu[DATA_W-1:0]};
              r_len     <= 1'b0;
              r_z       <= (w_alu[DATA_W-1:0] == '0);
              r_c       <= w_alu[DATA_W];
              r_err     <= 1'b0;
              r_rw      <= 1'b0;
            end
          end
        end
        S_ITER: if (w_last) begin
          r_state   <= S_WB;
          r_done    <= 1'b1;
          r_rd_addr <= r_rd;
          r_rd_data <= w_res_nxt;
          r_len     <= 1'b1;
          r_z       <= (w_res_nxt == '0);
          r_c       <= 1'b0;
          r_err     <= (r_rd == RD_LAST);
          r_rw      <= (r_rd == RD_LAST);
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.r_w          = r_rw;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.rd_data      = r_rd_data;
  assign bus.input_length = r_len;
  assign bus.flag_z       = r_z;
  assign bus.flag_c       = r_c;
  assign bus.flag_err     = r_err;
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed ops push expected write-backs, a negedge
// monitor pops and compares whenever done is presented.
module tb_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_if bus ();
  exec_unit dut (.i_clk(clk), .i_reset(reset), .bus(bus.slave));

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        len, z, c, err, wr;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errs = 0;
  int   checks = 0;
  int   ncyc = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, ncyc);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (!bus.r_w && !bus.done) chk("write_without_done", 0, 1);
    if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("wb_cycle", ncyc, mon_e.due);
        chk("rd_addr", int'(bus.rd_addr), int'(mon_e.addr));
        chk("rd_data", int'(bus.rd_data), int'(mon_e.data));
        chk("input_length", int'(bus.input_length), int'(mon_e.len));
        chk("flag_z", int'(bus.flag_z), int'(mon_e.z));
        chk("flag_c", int'(bus.flag_c), int'(mon_e.c));
        chk("flag_err", int'(bus.flag_err), int'(mon_e.err));
        chk("r_w", int'(bus.r_w), int'(!mon_e.wr));
        chk("busy_in_wb", int'(bus.busy), 1);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] rd, input logic [15:0] d, input logic len,
                       input logic z, input logic c, input logic err, input logic wr,
                       input int lat, input bit push);
    exp_t e;
    @(negedge clk); #2;
    bus.start = 1'b1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_sel = rd;
    e.addr = rd; e.data = d; e.len = len; e.z = z; e.c = c; e.err = err; e.wr = wr;
    e.due = ncyc + lat;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      chk("wb_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_r_w"}, int'(bus.r_w), 1);
    chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({tag, "_rd_data"}, int'(bus.rd_data), 0);
    chk({tag, "_len"}, int'(bus.input_length), 0);
    chk({tag, "_flags"}, int'({bus.flag_z, bus.flag_c, bus.flag_err}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.rs1_data = 8'd0; bus.rs2_data = 8'd0; bus.rd_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #2;
    chk_reset_vals("reset");

    //    op      A      B      rd    data       len z  c  err wr lat
    issue(3'b000, 8'hF0, 8'h20, 3'd2, 16'h0010, 0, 0, 1, 0, 1, 1, 1); wait_empty();
    // Result registers hold after write-back.
    repeat (2) @(negedge clk); #2;
    chk("hold_rd_data", int'(bus.rd_data), 16'h0010);
    chk("hold_flag_c", int'(bus.flag_c), 1);
    chk("hold_r_w", int'(bus.r_w), 1);
    issue(3'b001, 8'h05, 8'h07, 3'd1, 16'h00FE, 0, 0, 1, 0, 1, 1, 1); wait_empty();
    issue(3'b010, 8'hF0, 8'h0F, 3'd3, 16'h0000, 0, 1, 0, 0, 1, 1, 1); wait_empty();
    issue(3'b011, 8'hA0, 8'h05, 3'd4, 16'h00A5, 0, 0, 0, 0, 1, 1, 1); wait_empty();
    issue(3'b100, 8'hFF, 8'hFF, 3'd5, 16'h0000, 0, 1, 0, 0, 1, 1, 1); wait_empty();
    issue(3'b101, 8'h81, 8'h00, 3'd6, 16'h0002, 0, 0, 1, 0, 1, 1, 1); wait_empty();
    issue(3'b000, 8'h01, 8'hFF, 3'd7, 16'h0000, 0, 1, 1, 0, 1, 1, 1); wait_empty();
    issue(3'b110, 8'hFF, 8'hFF, 3'd4, 16'hFE01, 1, 0, 0, 0, 1, 9, 1); wait_empty();
    issue(3'b110, 8'h00, 8'h09, 3'd2, 16'h0000, 1, 1, 0, 0, 1, 9, 1); wait_empty();
    issue(3'b111, 8'd200, 8'd7, 3'd0, 16'h1C04, 1, 0, 0, 0, 1, 9, 1); wait_empty();
    issue(3'b111, 8'd200, 8'd0, 3'd5, 16'hFFC8, 1, 0, 0, 1, 1, 1, 1); wait_empty();
    issue(3'b110, 8'h03, 8'h05, 3'd7, 16'h000F, 1, 0, 0, 1, 0, 9, 1); wait_empty();

    // start held high through a MUL: only the MUL, then one ADD right after IDLE returns.
    issue(3'b110, 8'h02, 8'h03, 3'd1, 16'h0006, 1, 0, 0, 0, 1, 9, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #2;
      bus.start = 1'b1; bus.op = 3'b000; bus.rs1_data = 8'h01; bus.rs2_data = 8'h02; bus.rd_sel = 3'd3;
    end
    @(negedge clk); #2;
    q.push_back('{3'd3, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ncyc + 1});
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_empty();

    // Reset in the middle of a DIV aborts it with no write.
    issue(3'b111, 8'd200, 8'd7, 3'd0, 16'h0000, 0, 0, 0, 0, 0, 9, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #2;
    chk_reset_vals("abort");
    repeat (12) @(negedge clk);
    #3 chk("leftover_expect", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
